// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the execute-stage ALU and the ALU decoder that
//   feeds it.
//
//   Contents:
//     ALU_WIDTH  default datapath width
//     alu_op_e   3-bit ALU control code, as produced by the ALU decoder
//     is_shift   true for the two ops that run on the bit-serial shifter
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_serial_shifter.sv
// -----------------------------------------------------------------------------
// alu_serial_shifter
//   One-bit-per-cycle logical shifter. A load captures the source value, the
//   shift amount and the direction; every step cycle then moves the value one
//   position (zero fill) and decrements the remaining count.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     load       capture load_val / load_amt / load_left this cycle
//     load_val   value to be shifted
//     load_amt   number of single-bit steps still to perform (> 0 on load)
//     load_left  1 = shift left (SLL), 0 = shift right logical (SRL)
//     step       advance one bit this cycle
//     shifted    sreg moved by one more position (what the next step stores)
//     last       only one step remains; shifted is the final value
// -----------------------------------------------------------------------------
import alu_pkg::*;

module alu_serial_shifter #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [SHW-1:0]   load_amt,
  input  logic             load_left,
  input  logic             step,
  output logic [WIDTH-1:0] shifted,
  output logic             last
);

  logic [WIDTH-1:0] sreg_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             left_reg;

  logic [WIDTH-1:0] shl_bits;
  logic [WIDTH-1:0] shr_bits;

  // Single-position neighbours for each bit, with zero fill at the ends.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shl_bits[gi] = 1'b0;
      end else begin : g_shl
        assign shl_bits[gi] = sreg_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_bits[gi] = 1'b0;
      end else begin : g_shr
        assign shr_bits[gi] = sreg_reg[gi+1];
      end
    end
  endgenerate

  assign shifted = left_reg ? shl_bits : shr_bits;
  assign last    = (cnt_reg == SHW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_reg <= '0;
      cnt_reg  <= '0;
      left_reg <= 1'b0;
    end else if (load) begin
      sreg_reg <= load_val;
      cnt_reg  <= load_amt;
      left_reg <= load_left;
    end else if (step && (cnt_reg != '0)) begin
      sreg_reg <= shifted;
      cnt_reg  <= cnt_reg - SHW'(1);
    end
  end

endmodule : alu_serial_shifter

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle execute-stage ALU. Logic/arithmetic/compare ops finish one
//   cycle after accept; SLL/SRL with a non-zero amount run on the bit-serial
//   shifter and finish 1+shamt cycles after accept. Results come back over a
//   valid/ready handshake and are held stable under backpressure.
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     in_valid    request valid
//     in_ready    request can be accepted this cycle (depends on out_ready only)
//     ALUcontrol  operation code (alu_op_e)
//     src_a       operand A / shift source
//     src_b       operand B; [SHW-1:0] is the shift amount for shifts
//     out_valid   result valid
//     out_ready   consumer takes the result
//     result      registered result
//     zero        registered (result == 0), meaningful while out_valid
// -----------------------------------------------------------------------------
import alu_pkg::*;

module seq_alu #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUcontrol,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;

  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             start_shift;
  logic [WIDTH-1:0] alu_value;
  logic             slt_lt;

  logic [WIDTH-1:0] sh_value;
  logic             sh_last;

  assign op          = alu_op_e'(ALUcontrol);
  assign shamt       = src_b[SHW-1:0];
  assign start_shift = is_shift(op) && (shamt != '0);

  // A finished result may be handed off and replaced in the same cycle, so
  // DONE accepts a new request whenever the consumer is taking the old one.
  assign in_ready  = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;

  assign slt_lt = ($signed(src_a) < $signed(src_b));

  // Single-cycle datapath. Shift ops only reach this path with shamt == 0,
  // where the result is simply the unshifted source.
  always_comb begin
    alu_value = '0;
    case (op)
      ALU_ADD: alu_value = src_a + src_b;
      ALU_SUB: alu_value = src_a - src_b;
      ALU_AND: alu_value = src_a & src_b;
      ALU_OR:  alu_value = src_a | src_b;
      ALU_XOR: alu_value = src_a ^ src_b;
      ALU_SLL: alu_value = src_a;
      ALU_SRL: alu_value = src_a;
      ALU_SLT: alu_value = {{(WIDTH-1){1'b0}}, slt_lt};
      default: alu_value = '0;
    endcase
  end

  alu_serial_shifter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && start_shift),
    .load_val (src_a),
    .load_amt (shamt),
    .load_left(op == ALU_SLL),
    .step     (state_reg == ST_SHIFT),
    .shifted  (sh_value),
    .last     (sh_last)
  );

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    zero_next   = zero_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (sh_last) begin
          result_next = sh_value;
          zero_next   = (sh_value == '0);
          state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Dispatch is identical from IDLE and from a DONE that is being drained.
    if (accept) begin
      if (start_shift) begin
        state_next = ST_SHIFT;
      end else begin
        result_next = alu_value;
        zero_next   = (alu_value == '0);
        state_next  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

endmodule : seq_alu

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu. A transaction-level model (at most one
//   outstanding op, its expected value and the cycle it becomes visible) is
//   checked against the DUT on every negative clock edge; directed sequences
//   add literal expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   ALUcontrol = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int txn   = 0;

  // transaction model state
  bit           pend = 1'b0;
  int           due  = 0;
  logic [W-1:0] exp_res = '0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUcontrol(ALUcontrol),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
    if ((op == 3'd5 || op == 3'd6) && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    bit exp_ov, exp_ir;
    if (!rst_n) begin
      pend = 1'b0;
      chk("rst_out_valid", W'(out_valid), 0);
      chk("rst_result", result, 0);
      chk("rst_zero", W'(zero), 0);
    end else begin
      exp_ov = pend && (cyc >= due);
      chk("out_valid", W'(out_valid), W'(exp_ov));
      if (exp_ov) begin
        chk("result", result, exp_res);
        chk("zero", W'(zero), W'(exp_res == '0));
      end
      exp_ir = !pend || (exp_ov && out_ready);
      chk("in_ready", W'(in_ready), W'(exp_ir));
      if (exp_ov && out_ready) begin
        pend = 1'b0;
        txn++;
        $display("txn %0d: cycle %0d result=%h zero=%b", txn, cyc, result, zero);
      end
      if (in_valid && exp_ir) begin
        pend    = 1'b1;
        due     = cyc + ref_lat(ALUcontrol, src_b);
        exp_res = ref_alu(ALUcontrol, src_a, src_b);
      end
    end
  end

  // One op from an idle/draining DUT with a literal expected value and latency.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp,
                       input bit exp_z, input int exp_lat);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; ALUcontrol = op; src_a = a; src_b = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; ALUcontrol = 3'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      chk({name, "_busy_in_ready"}, W'(in_ready), 0);
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_result"}, result, exp);
    chk({name, "_zero"}, W'(zero), W'(exp_z));
  endtask

  logic [2:0]   b2b_op  [4] = '{3'd2, 3'd3, 3'd2, 3'd3};
  logic [W-1:0] b2b_a   [4] = '{32'hF0F0_F0F0, 32'h0F00_0000, 32'h1234_5678, 32'h8000_0001};
  logic [W-1:0] b2b_b   [4] = '{32'hFF00_FF00, 32'h0000_00F0, 32'h0000_0000, 32'h0000_0010};
  logic [W-1:0] b2b_exp [4] = '{32'hF000_F000, 32'h0F00_00F0, 32'h0000_0000, 32'h8000_0011};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", W'(out_valid), 0);
    chk("reset_in_ready", W'(in_ready), 1);
    rst_n = 1'b1;

    do_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1);
    do_op("sub_neg", 3'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    do_op("slt_true", 3'd7, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1);
    do_op("slt_false", 3'd7, 32'h1, 32'h8000_0000, 32'h0, 1'b1, 1);
    do_op("sll_31", 3'd5, 32'h1, 32'hFFFF_FF1F, 32'h8000_0000, 1'b0, 32);
    do_op("srl_0", 3'd6, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1);
    do_op("srl_4", 3'd6, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 5);

    // Backpressure, then back-to-back accept while draining.
    do_op("xor_bp", 3'd4, 32'hF0F0_0000, 32'h0F0F_0000, 32'hFFFF_0000, 1'b0, 1);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", W'(out_valid), 1);
      chk("bp_result", result, 32'hFFFF_0000);
      chk("bp_in_ready", W'(in_ready), 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; ALUcontrol = 3'd0; src_a = 32'd3; src_b = 32'd4;
    #1;
    chk("bp_release_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", W'(out_valid), 1);
    chk("bp_next_result", result, 32'd7);

    // Four single-cycle ops streamed with both sides ready.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; ALUcontrol = b2b_op[i]; src_a = b2b_a[i]; src_b = b2b_b[i];
      @(posedge clk); #1;
      chk("b2b_valid", W'(out_valid), 1);
      chk("b2b_result", result, b2b_exp[i]);
    end
    in_valid = 1'b0;

    // Reset in the middle of a 10-bit SRL.
    @(posedge clk); #1;
    in_valid = 1'b1; ALUcontrol = 3'd6; src_a = 32'hFFFF_0000; src_b = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shift_busy", W'(out_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", W'(out_valid), 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_in_ready", W'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      chk("no_stale_valid", W'(out_valid), 0);
      chk("no_stale_result", result, 0);
    end
    do_op("add_after_rst", 3'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1);

    // Randomised traffic; the negedge model checks every cycle.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 9) < 6);
      out_ready  = ($urandom_range(0, 9) < 7);
      ALUcontrol = 3'($urandom);
      src_a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      src_b      = ($urandom_range(0, 5) == 0) ? src_a : $urandom;
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_out_valid", W'(out_valid), 0);
    chk("drain_in_ready", W'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_alu
